// File: rtl/crc32_serial_ctrl.sv
// Frame controller for a bit-serial CRC engine: serialises a byte stream MSB-first into the engine,
// strobes finish, gathers the serial result and holds it until the consumer accepts it.
module crc32_serial_ctrl #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CRC_W  = 32,
    parameter int unsigned LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic              crc_load,
    output logic              crc_bit,
    output logic              crc_finish,
    input  logic              crc_sout,
    output logic [CRC_W-1:0]  res_crc,
    output logic [LEN_W-1:0]  res_len,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              underrun,
    output logic              busy
);

    localparam int unsigned BIT_CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned RD_CW  = (CRC_W > 1) ? $clog2(CRC_W) : 1;
    localparam logic [BIT_CW-1:0] LAST_BIT = BIT_CW'(DATA_W - 1);
    localparam logic [RD_CW-1:0]  LAST_RD  = RD_CW'(CRC_W - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StShift,
        StFinish,
        StReadout,
        StDone
    } state_e;

    state_e             r_state;
    logic [DATA_W-1:0]  r_shift;
    logic               r_last;
    logic [LEN_W-1:0]   r_byte_cnt;
    logic [BIT_CW-1:0]  r_bit_cnt;
    logic [RD_CW-1:0]   r_rd_cnt;
    logic [CRC_W-1:0]   r_res_crc;
    logic [LEN_W-1:0]   r_res_len;

    state_e             w_state_d;
    logic [DATA_W-1:0]  w_shift_d;
    logic               w_last_d;
    logic [LEN_W-1:0]   w_byte_cnt_d;
    logic [BIT_CW-1:0]  w_bit_cnt_d;
    logic [RD_CW-1:0]   w_rd_cnt_d;
    logic [CRC_W-1:0]   w_res_crc_d;
    logic [LEN_W-1:0]   w_res_len_d;
    logic               w_in_ready;
    logic               w_crc_load;
    logic               w_crc_bit;
    logic               w_crc_finish;
    logic               w_underrun;
    logic [LEN_W-1:0]   w_byte_cnt_inc;

    // Saturating frame length: stops at all-ones instead of wrapping.
    assign w_byte_cnt_inc = (r_byte_cnt == {LEN_W{1'b1}}) ? r_byte_cnt
                                                          : r_byte_cnt + LEN_W'(1);

    always_comb begin
        w_state_d    = r_state;
        w_shift_d    = r_shift;
        w_last_d     = r_last;
        w_byte_cnt_d = r_byte_cnt;
        w_bit_cnt_d  = r_bit_cnt;
        w_rd_cnt_d   = r_rd_cnt;
        w_res_crc_d  = r_res_crc;
        w_res_len_d  = r_res_len;
        w_in_ready   = 1'b0;
        w_crc_load   = 1'b0;
        w_crc_bit    = 1'b0;
        w_crc_finish = 1'b0;
        w_underrun   = 1'b0;

        unique case (r_state)
            StIdle: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_shift_d    = in_data;
                    w_last_d     = in_last;
                    w_byte_cnt_d = LEN_W'(1);
                    w_state_d    = StLoad;
                end
            end
            StLoad: begin
                w_crc_load  = 1'b1;
                w_bit_cnt_d = '0;
                w_state_d   = StShift;
            end
            StShift: begin
                w_crc_bit   = r_shift[DATA_W-1];
                w_shift_d   = r_shift << 1;
                w_bit_cnt_d = r_bit_cnt + BIT_CW'(1);
                if (r_bit_cnt == LAST_BIT) begin
                    if (r_last) begin
                        w_state_d = StFinish;
                    end else begin
                        // Next byte must land in this slot; the engine cannot stall.
                        w_in_ready = 1'b1;
                        if (in_valid) begin
                            w_shift_d    = in_data;
                            w_last_d     = in_last;
                            w_byte_cnt_d = w_byte_cnt_inc;
                            w_bit_cnt_d  = '0;
                        end else begin
                            w_underrun = 1'b1;
                            w_state_d  = StIdle;
                        end
                    end
                end
            end
            StFinish: begin
                w_crc_finish = 1'b1;
                w_rd_cnt_d   = '0;
                w_state_d    = StReadout;
            end
            StReadout: begin
                w_res_crc_d = {r_res_crc[CRC_W-2:0], crc_sout};
                w_rd_cnt_d  = r_rd_cnt + RD_CW'(1);
                if (r_rd_cnt == LAST_RD) begin
                    w_res_len_d = r_byte_cnt;
                    w_state_d   = StDone;
                end
            end
            StDone: begin
                if (res_ready) begin
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_shift    <= '0;
            r_last     <= 1'b0;
            r_byte_cnt <= '0;
            r_bit_cnt  <= '0;
            r_rd_cnt   <= '0;
            r_res_crc  <= '0;
            r_res_len  <= '0;
        end else begin
            r_state    <= w_state_d;
            r_shift    <= w_shift_d;
            r_last     <= w_last_d;
            r_byte_cnt <= w_byte_cnt_d;
            r_bit_cnt  <= w_bit_cnt_d;
            r_rd_cnt   <= w_rd_cnt_d;
            r_res_crc  <= w_res_crc_d;
            r_res_len  <= w_res_len_d;
        end
    end

    // A byte offered while reset is held would be silently discarded, so refuse it.
    assign in_ready   = w_in_ready & ~rst;
    assign crc_load   = w_crc_load;
    assign crc_bit    = w_crc_bit;
    assign crc_finish = w_crc_finish;
    assign underrun   = w_underrun;
    assign res_crc    = r_res_crc;
    assign res_len    = r_res_len;
    assign res_valid  = (r_state == StDone);
    assign busy       = (r_state != StIdle);

endmodule

// File: tb/tb_crc32_serial_ctrl.sv
// Bench for crc32_serial_ctrl: bit-serial engine mock on the CRC side, byte-wise CRC-32 reference
// model, a vector table of fixed frames plus random frames and hand-written corner sequences.
module tb_crc32_serial_ctrl;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CRC_W  = 32;
    localparam int unsigned LEN_W  = 8;
    localparam logic [31:0] POLY   = 32'h04C1_1DB7;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic              crc_load;
    logic              crc_bit;
    logic              crc_finish;
    logic              crc_sout;
    logic [CRC_W-1:0]  res_crc;
    logic [LEN_W-1:0]  res_len;
    logic              res_valid;
    logic              res_ready;
    logic              underrun;
    logic              busy;

    int n_chk  = 0;
    int n_fail = 0;

    crc32_serial_ctrl #(.DATA_W(DATA_W), .CRC_W(CRC_W), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .crc_load  (crc_load),
        .crc_bit   (crc_bit),
        .crc_finish(crc_finish),
        .crc_sout  (crc_sout),
        .res_crc   (res_crc),
        .res_len   (res_len),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .underrun  (underrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Engine mock: bit-serial CRC-32, init all-ones, consumes bits strictly between load and finish.
    bit          fixed_mode = 1'b0;
    logic [31:0] fixed_val  = 32'h0;
    logic [31:0] eng_reg    = 32'h0;
    logic [31:0] eng_out    = 32'h0;
    logic        eng_active = 1'b0;
    logic        eng_bits[$];

    always @(posedge clk) begin
        if (rst) begin
            eng_active <= 1'b0;
            eng_out    <= 32'h0;
            eng_reg    <= 32'hFFFF_FFFF;
        end else if (crc_load) begin
            eng_reg    <= 32'hFFFF_FFFF;
            eng_active <= 1'b1;
            eng_bits.delete();
        end else if (crc_finish) begin
            eng_active <= 1'b0;
            eng_out    <= fixed_mode ? fixed_val : eng_reg;
        end else begin
            if (eng_active) begin
                eng_reg <= {eng_reg[30:0], 1'b0} ^ ((eng_reg[31] ^ crc_bit) ? POLY : 32'h0);
                eng_bits.push_back(crc_bit);
            end
            eng_out <= eng_out << 1;
        end
    end
    assign crc_sout = eng_out[31];

    // Event monitor, sampled mid-cycle.
    int load_cyc = -1, finish_cyc = -1, fin_cnt = 0, und_cnt = 0, ir_cnt = 0;
    always @(negedge clk) begin
        if (crc_load) load_cyc <= cyc;
        if (crc_finish) begin
            finish_cyc <= cyc;
            fin_cnt    <= fin_cnt + 1;
        end
        if (underrun) und_cnt <= und_cnt + 1;
        if (in_ready) ir_cnt <= ir_cnt + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_crc(input logic [7:0] q[$]);
        logic [31:0] c = 32'hFFFF_FFFF;
        foreach (q[i]) begin
            c = c ^ {q[i], 24'h0};
            for (int k = 0; k < 8; k++) c = c[31] ? ((c << 1) ^ POLY) : (c << 1);
        end
        return c;
    endfunction

    // Drives one frame with in_valid held, then checks timing, bits, result and the DONE handshake.
    task automatic run_frame(input logic [7:0] q[$], input logic [LEN_W-1:0] exp_len,
                             input int exp_lat, input int rdy_dly, input string tag);
        int          n     = q.size();
        int          idx   = 0;
        int          t     = -1;
        int          loops = 0;
        int          ir0   = ir_cnt;
        int          vcyc;
        int          bad   = 0;
        logic [31:0] exp_crc = fixed_mode ? fixed_val : ref_crc(q);

        while (idx < n && loops < 8 * n + 50) begin
            in_valid = 1'b1;
            in_data  = q[idx];
            in_last  = (idx == n - 1);
            @(negedge clk);
            if (in_ready) begin
                if (t < 0) t = cyc;
                idx++;
            end
            @(posedge clk);
            #1;
            loops++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk({tag, " accepted"}, 64'(idx), 64'(n));

        loops = 0;
        do begin
            @(negedge clk);
            loops++;
        end while (!res_valid && loops < 8 * n + 100);
        chk({tag, " res_valid seen"}, 64'(res_valid), 64'd1);
        vcyc = cyc;
        chk({tag, " load cycle"}, 64'(load_cyc - t), 64'd1);
        chk({tag, " finish cycle"}, 64'(finish_cyc - t), 64'(2 + 8 * n));
        chk({tag, " valid latency"}, 64'(vcyc - t), 64'(exp_lat));
        chk({tag, " in_ready cycles"}, 64'(ir_cnt - ir0), 64'(n));
        chk({tag, " bit count"}, 64'(eng_bits.size()), 64'(8 * n));
        for (int i = 0; i < eng_bits.size() && i < 8 * n; i++)
            if (eng_bits[i] !== q[i / 8][7 - (i % 8)]) bad++;
        chk({tag, " serial bits"}, 64'(bad), 64'd0);
        chk({tag, " res_crc"}, 64'(res_crc), 64'(exp_crc));
        chk({tag, " res_len"}, 64'(res_len), 64'(exp_len));

        for (int k = 0; k < rdy_dly; k++) begin
            @(negedge clk);
            chk({tag, " hold {valid,ready,len,crc}"}, {res_valid, in_ready, res_len, res_crc},
                {1'b1, 1'b0, exp_len, exp_crc});
        end
        @(posedge clk);
        #1 res_ready = 1'b1;
        @(negedge clk);
        chk({tag, " valid at accept"}, 64'(res_valid), 64'd1);
        @(posedge clk);
        #1 res_ready = 1'b0;
        @(negedge clk);
        chk({tag, " after accept {valid,ready,busy}"}, {res_valid, in_ready, busy}, 3'b010);
        chk({tag, " crc kept"}, 64'(res_crc), 64'(exp_crc));
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse(input string tag);
        rst = 1'b1;
        @(negedge clk);
        chk({tag, " in_ready during rst"}, 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk({tag, " outputs after rst"},
            {crc_load, crc_bit, crc_finish, res_valid, underrun, busy, res_len, res_crc}, 64'd0);
        chk({tag, " idle ready after rst"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int              n;
        logic [31:0]     bytes;  // byte 0 in [31:24]
        logic [LEN_W-1:0] exp_len;
        int              exp_lat;
        int              rdy_dly;
    } vec_t;

    initial begin
        vec_t        tbl[5];
        logic [7:0]  q[$];
        int          t, u0, f0;

        tbl[0] = '{n: 1, bytes: 32'hFF00_0000, exp_len: 8'd1, exp_lat: 43, rdy_dly: 0};
        tbl[1] = '{n: 3, bytes: 32'h3132_3300, exp_len: 8'd3, exp_lat: 59, rdy_dly: 2};
        tbl[2] = '{n: 2, bytes: 32'h00FF_0000, exp_len: 8'd2, exp_lat: 51, rdy_dly: 0};
        tbl[3] = '{n: 4, bytes: 32'h8001_7E81, exp_len: 8'd4, exp_lat: 67, rdy_dly: 1};
        tbl[4] = '{n: 1, bytes: 32'h0000_0000, exp_len: 8'd1, exp_lat: 43, rdy_dly: 20};

        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_pulse("init");

        // Single byte 0xA5 with the engine returning a fixed result.
        fixed_mode = 1'b1;
        fixed_val  = 32'hDEAD_BEEF;
        q = '{8'hA5};
        run_frame(q, 8'd1, 43, 0, "a5");
        fixed_mode = 1'b0;

        foreach (tbl[i]) begin
            q.delete();
            for (int b = 0; b < tbl[i].n; b++) q.push_back(tbl[i].bytes[31 - 8 * b -: 8]);
            run_frame(q, tbl[i].exp_len, tbl[i].exp_lat, tbl[i].rdy_dly, $sformatf("vec%0d", i));
        end

        // Underrun: first byte of a 2-byte frame, nothing offered in the last-bit slot.
        u0 = und_cnt;
        f0 = fin_cnt;
        in_valid = 1'b1;
        in_data  = 8'hC3;
        in_last  = 1'b0;
        @(negedge clk);
        t = cyc;
        chk("underrun first accept", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("underrun pulse", {64'(cyc - t), 63'd0, underrun}, {64'd9, 64'd1});
        @(negedge clk);
        chk("underrun idle {valid,ready,busy}", {res_valid, in_ready, busy}, 3'b010);
        chk("underrun count", 64'(und_cnt - u0), 64'd1);
        chk("underrun no finish", 64'(fin_cnt - f0), 64'd0);
        @(posedge clk);
        #1;
        q = '{8'h12, 8'h34};
        run_frame(q, 8'd2, 51, 0, "post-underrun");

        // Reset mid-SHIFT.
        in_valid = 1'b1;
        in_data  = 8'h5A;
        in_last  = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset_pulse("rst-shift");
        q = '{8'h9C, 8'h01, 8'hE7};
        run_frame(q, 8'd3, 59, 0, "post-rst-shift");

        // Reset mid-READOUT.
        in_valid = 1'b1;
        in_data  = 8'h77;
        in_last  = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1 in_valid = 1'b0;
        in_last = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        reset_pulse("rst-readout");
        q = '{8'h42};
        run_frame(q, 8'd1, 43, 0, "post-rst-readout");

        // Random frames against the reference model.
        for (int r = 0; r < 6; r++) begin
            int n = $urandom_range(1, 8);
            q.delete();
            for (int b = 0; b < n; b++) q.push_back(8'($urandom));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            run_frame(q, LEN_W'(n), 35 + 8 * n, $urandom_range(0, 5), $sformatf("rand%0d", r));
        end

        // Length counter saturation: 257 bytes into an 8-bit counter.
        q.delete();
        for (int b = 0; b < 257; b++) q.push_back(8'($urandom));
        run_frame(q, 8'hFF, 35 + 8 * 257, 0, "saturate");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
